// File: rtl/mem8x8_arbiter.sv
// Round-robin two-requester access controller for the 8x8 memory array.
// Sequences address, write-enable and output-enable with fixed setup/access/hold phases.
module mem8x8_arbiter #(
    parameter int DATA_W        = 8,
    parameter int ADR_W         = 3,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADR_W-1:0]  adr_a,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADR_W-1:0]  adr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              ack_a,
    output logic              ack_b,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADR_W-1:0]  mem_adr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    output logic              mem_oe,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic {
        SIDE_A = 1'b0,
        SIDE_B = 1'b1
    } side_t;

    // Every output is a field of this register, so no input reaches a pin combinationally.
    typedef struct packed {
        state_t             state;
        logic [CNT_W-1:0]   cnt;
        logic               op_we;
        side_t              side;
        side_t              prio;
        logic [ADR_W-1:0]   mem_adr;
        logic [DATA_W-1:0]  mem_din;
        logic               mem_we;
        logic               mem_oe;
        logic               ack_a;
        logic               ack_b;
        logic [DATA_W-1:0]  rdata;
        logic               busy;
    } regs_t;

    regs_t r;
    regs_t nx;

    logic              grant_b;
    logic              grant_we;
    logic [ADR_W-1:0]  grant_adr;
    logic [DATA_W-1:0] grant_din;

    assign grant_b   = req_b && (!req_a || (r.prio == SIDE_B));
    assign grant_we  = grant_b ? we_b    : we_a;
    assign grant_adr = grant_b ? adr_b   : adr_a;
    assign grant_din = grant_b ? wdata_b : wdata_a;

    // NOTE: the all-zero reset value encodes state IDLE and prio SIDE_A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            r <= nx;
        end
    end

    always_comb begin
        // NOTE: nx gets a full default first so no path through the case can infer a latch.
        nx       = r;
        nx.ack_a = 1'b0;
        nx.ack_b = 1'b0;

        case (r.state)
            IDLE: begin
                if (req_a || req_b) begin
                    nx.side    = grant_b ? SIDE_B : SIDE_A;
                    nx.op_we   = grant_we;
                    nx.mem_adr = grant_adr;
                    nx.mem_din = grant_din;
                    nx.mem_oe  = !grant_we;
                    nx.busy    = 1'b1;
                    nx.state   = SETUP;
                end
            end

            SETUP: begin
                nx.cnt    = CNT_W'(ACCESS_CYCLES - 1);
                nx.mem_we = r.op_we;
                nx.mem_oe = !r.op_we;
                nx.state  = ACCESS;
            end

            ACCESS: begin
                if (r.cnt == '0) begin
                    nx.mem_we = 1'b0;
                    nx.mem_oe = 1'b0;
                    if (!r.op_we) begin
                        nx.rdata = mem_dout;
                    end
                    nx.ack_a = (r.side == SIDE_A);
                    nx.ack_b = (r.side == SIDE_B);
                    nx.state = DONE;
                end else begin
                    nx.cnt = r.cnt - 1'b1;
                end
            end

            DONE: begin
                nx.prio  = (r.side == SIDE_A) ? SIDE_B : SIDE_A;
                nx.busy  = 1'b0;
                nx.state = IDLE;
            end

            default: begin
                nx.state = IDLE;
            end
        endcase
    end

    assign ack_a   = r.ack_a;
    assign ack_b   = r.ack_b;
    assign rdata   = r.rdata;
    assign busy    = r.busy;
    assign mem_adr = r.mem_adr;
    assign mem_din = r.mem_din;
    assign mem_we  = r.mem_we;
    assign mem_oe  = r.mem_oe;

endmodule

// File: tb/tb_mem8x8_arbiter.sv
// Directed bench for mem8x8_arbiter: one instance with ACCESS_CYCLES=1 and one with 3,
// each attached to its own behavioural 8x8 memory.
module tb_mem8x8_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
    logic [2:0] adr_a = '0, adr_b = '0;
    logic [7:0] wdata_a = '0, wdata_b = '0;

    logic       ack_a1, ack_b1, busy1, mem_we1, mem_oe1;
    logic [2:0] mem_adr1;
    logic [7:0] rdata1, mem_din1, mem_dout1;
    logic       ack_a3, ack_b3, busy3, mem_we3, mem_oe3;
    logic [2:0] mem_adr3;
    logic [7:0] rdata3, mem_din3, mem_dout3;

    logic [7:0] mem1 [8] = '{default: 8'h00};
    logic [7:0] mem3 [8] = '{default: 8'h00};

    int n_vec  = 0;
    int n_fail = 0;
    int excl_viol = 0;
    int both_ack  = 0;

    always #5 clk = ~clk;

    mem8x8_arbiter #(.DATA_W(8), .ADR_W(3), .ACCESS_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .we_a(we_a), .adr_a(adr_a), .wdata_a(wdata_a),
        .req_b(req_b), .we_b(we_b), .adr_b(adr_b), .wdata_b(wdata_b),
        .ack_a(ack_a1), .ack_b(ack_b1), .rdata(rdata1), .busy(busy1),
        .mem_adr(mem_adr1), .mem_din(mem_din1), .mem_we(mem_we1), .mem_oe(mem_oe1),
        .mem_dout(mem_dout1)
    );

    mem8x8_arbiter #(.DATA_W(8), .ADR_W(3), .ACCESS_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .we_a(we_a), .adr_a(adr_a), .wdata_a(wdata_a),
        .req_b(req_b), .we_b(we_b), .adr_b(adr_b), .wdata_b(wdata_b),
        .ack_a(ack_a3), .ack_b(ack_b3), .rdata(rdata3), .busy(busy3),
        .mem_adr(mem_adr3), .mem_din(mem_din3), .mem_we(mem_we3), .mem_oe(mem_oe3),
        .mem_dout(mem_dout3)
    );

    always @(posedge clk) if (mem_we1) mem1[mem_adr1] <= mem_din1;
    always @(posedge clk) if (mem_we3) mem3[mem_adr3] <= mem_din3;
    assign mem_dout1 = mem_oe1 ? mem1[mem_adr1] : 8'h00;
    assign mem_dout3 = mem_oe3 ? mem3[mem_adr3] : 8'h00;

    always @(negedge clk) begin
        if ((mem_we1 && mem_oe1) || (mem_we3 && mem_oe3)) excl_viol++;
        if ((ack_a1 && ack_b1) || (ack_a3 && ack_b3)) both_ack++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One transaction on a chosen instance/side; returns at the negedge where ack is seen
    // (or after a 20-cycle budget) with per-cycle observations of the memory strobes.
    task automatic txn(input bit d3, input bit side_b, input logic we, input logic [2:0] adr,
                       input logic [7:0] wd, output int lat, output int we_cyc, output int oe_cyc,
                       output int we_runs, output logic [2:0] adr_seen, output logic [7:0] din_seen);
        logic ack, mw, mo, prev_we;
        @(negedge clk);
        if (side_b) begin
            req_b = 1'b1; we_b = we; adr_b = adr; wdata_b = wd;
        end else begin
            req_a = 1'b1; we_a = we; adr_a = adr; wdata_a = wd;
        end
        lat = 0; we_cyc = 0; oe_cyc = 0; we_runs = 0; prev_we = 1'b0;
        adr_seen = '0; din_seen = '0;
        do begin
            @(negedge clk);
            lat++;
            ack = d3 ? (side_b ? ack_b3 : ack_a3) : (side_b ? ack_b1 : ack_a1);
            mw  = d3 ? mem_we3 : mem_we1;
            mo  = d3 ? mem_oe3 : mem_oe1;
            if (mw) begin
                we_cyc++;
                adr_seen = d3 ? mem_adr3 : mem_adr1;
                din_seen = d3 ? mem_din3 : mem_din1;
                if (!prev_we) we_runs++;
            end
            if (mo) oe_cyc++;
            prev_we = mw;
        end while (!ack && lat < 20);
        if (side_b) req_b = 1'b0;
        else        req_a = 1'b0;
    endtask

    typedef struct {
        logic       we;
        logic [2:0] adr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int lat, wc, oc, runs, na, nb, low, seen;
        logic [2:0] as;
        logic [7:0] ds;
        logic [3:0] ord;

        vecs[0] = '{1'b1, 3'd3, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 3'd3, 8'h00, 8'hA5};
        vecs[2] = '{1'b1, 3'd0, 8'h3C, 8'hA5};
        vecs[3] = '{1'b1, 3'd7, 8'h81, 8'hA5};
        vecs[4] = '{1'b0, 3'd0, 8'h00, 8'h3C};
        vecs[5] = '{1'b1, 3'd0, 8'h5A, 8'h3C};
        vecs[6] = '{1'b0, 3'd7, 8'h00, 8'h81};
        vecs[7] = '{1'b0, 3'd0, 8'h00, 8'h5A};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset_outputs",
              32'({busy1, mem_we1, mem_oe1, ack_a1, ack_b1, mem_adr1, mem_din1, rdata1}), 0);
        rst_n = 1'b1;

        // Table of single A transactions on the ACCESS_CYCLES=1 instance
        for (int i = 0; i < 8; i++) begin
            txn(1'b0, 1'b0, vecs[i].we, vecs[i].adr, vecs[i].wdata, lat, wc, oc, runs, as, ds);
            check($sformatf("v%0d_ack_latency", i), 32'(lat), 3);
            check($sformatf("v%0d_we_cycles", i), 32'(wc), vecs[i].we ? 1 : 0);
            check($sformatf("v%0d_oe_cycles", i), 32'(oc), vecs[i].we ? 0 : 2);
            if (vecs[i].we) begin
                check($sformatf("v%0d_mem_adr", i), 32'(as), 32'(vecs[i].adr));
                check($sformatf("v%0d_mem_din", i), 32'(ds), 32'(vecs[i].wdata));
            end
            check($sformatf("v%0d_rdata_ack", i), 32'(rdata1), 32'(vecs[i].exp_rdata));
            @(negedge clk);
            check($sformatf("v%0d_idle_after", i), 32'({ack_a1, busy1}), 0);
            check($sformatf("v%0d_rdata_held", i), 32'(rdata1), 32'(vecs[i].exp_rdata));
        end

        // Both requesters held; each drops on its ack and re-raises
        do_reset();
        req_a = 1'b1; we_a = 1'b0; adr_a = 3'd3;
        req_b = 1'b1; we_b = 1'b0; adr_b = 3'd7;
        na = 0; nb = 0; low = 0; ord = '0;
        for (int c = 0; c < 60 && (na + nb) < 4; c++) begin
            @(negedge clk);
            if ((na + nb) > 0 && !busy1) low++;
            if (ack_a1) begin
                ord = {ord[2:0], 1'b0}; na++; req_a = 1'b0;
            end else if (!req_a && na < 2) begin
                req_a = 1'b1;
            end
            if (ack_b1) begin
                ord = {ord[2:0], 1'b1}; nb++; req_b = 1'b0;
            end else if (!req_b && nb < 2) begin
                req_b = 1'b1;
            end
        end
        check("rr_ack_count", 32'(na + nb), 4);
        check("rr_order_ABAB", 32'(ord), 32'h5);
        check("rr_idle_gaps", 32'(low), 3);

        // Asynchronous reset during the access phase of a write
        txn(1'b0, 1'b0, 1'b0, 3'd3, 8'h00, lat, wc, oc, runs, as, ds);
        check("pre_abort_latency", 32'(lat), 3);
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b1; adr_a = 3'd5; wdata_a = 8'hC3;
        @(negedge clk);
        @(negedge clk);
        check("abort_we_high", 32'({mem_we1, busy1}), 32'h3);
        #2;
        rst_n = 1'b0;
        req_a = 1'b0;
        #1;
        check("abort_async_drop", 32'({mem_we1, busy1}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ack_a1) seen++;
        end
        check("abort_no_ack", 32'(seen), 0);
        check("abort_no_write", 32'(mem1[5]), 0);
        req_a = 1'b1; we_a = 1'b0; adr_a = 3'd3;
        req_b = 1'b1; we_b = 1'b0; adr_b = 3'd7;
        seen = 0;
        for (int c = 0; c < 20 && !(ack_a1 || ack_b1); c++) @(negedge clk);
        check("abort_prio_A", 32'({ack_a1, ack_b1}), 32'h2);
        req_a = 1'b0;
        for (int c = 0; c < 20 && !ack_b1; c++) @(negedge clk);
        check("abort_then_B", 32'(ack_b1), 1);
        req_b = 1'b0;

        // Inputs changed after grant and req dropped during access
        @(negedge clk);
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b1; adr_a = 3'd2; wdata_a = 8'h66;
        @(negedge clk);
        adr_a = 3'd0; wdata_a = 8'hFF;
        @(negedge clk);
        req_a = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            @(negedge clk);
            if (ack_a1) seen = c + 1;
        end
        check("late_change_ack", 32'(seen), 1);
        check("late_change_mem2", 32'(mem1[2]), 32'h66);
        check("late_change_mem0", 32'(mem1[0]), 32'h5A);

        // ACCESS_CYCLES=3 instance: B write then A read-back
        do_reset();
        txn(1'b1, 1'b1, 1'b1, 3'd7, 8'h3C, lat, wc, oc, runs, as, ds);
        check("ac3_w_latency", 32'(lat), 5);
        check("ac3_w_we_cycles", 32'(wc), 3);
        check("ac3_w_we_runs", 32'(runs), 1);
        check("ac3_w_oe_cycles", 32'(oc), 0);
        check("ac3_w_adr_din", 32'({as, ds}), 32'({3'd7, 8'h3C}));
        check("ac3_w_mem7", 32'(mem3[7]), 32'h3C);
        @(negedge clk);
        txn(1'b1, 1'b0, 1'b0, 3'd7, 8'h00, lat, wc, oc, runs, as, ds);
        check("ac3_r_latency", 32'(lat), 5);
        check("ac3_r_oe_cycles", 32'(oc), 4);
        check("ac3_r_we_cycles", 32'(wc), 0);
        check("ac3_r_rdata", 32'(rdata3), 32'h3C);

        check("we_oe_exclusive", 32'(excl_viol), 0);
        check("ack_exclusive", 32'(both_ack), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mem8x8_arbiter.md
Name: mem8x8_arbiter

Overview:
- Two-port access controller and arbiter for the 8x8 memory array.
- Accepts independent read/write requests from requesters A and B and grants one at a time with round-robin priority.
- Sequences the memory's row-select demux address, write-enable and tri-state output-enable with fixed setup/access/hold timing.
- Returns read data and an acknowledge pulse to the granted requester.

Parameters:
DATA_W, 8, memory word width (the array is 8 bits wide)
ADR_W, 3, word address width (8 rows)
ACCESS_CYCLES, 1, cycles mem_we/mem_oe stay in the access phase; legal range 1..15

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_a  input  1  request from A, level; held high until ack_a
we_a  input  1  A: 1 = write, 0 = read
adr_a  input  ADR_W  A word address
wdata_a  input  DATA_W  A write data
req_b, we_b, adr_b, wdata_b  input  1/1/ADR_W/DATA_W  same meanings for B
ack_a  output  1  one-cycle pulse: A transaction complete
ack_b  output  1  one-cycle pulse: B transaction complete
rdata  output  DATA_W  read result, valid on ack cycle, held until next read completes
busy  output  1  high in every state except IDLE
mem_adr  output  ADR_W  address to memory row demux
mem_din  output  DATA_W  write data to memory
mem_we  output  1  memory write enable
mem_oe  output  1  memory tri-state output enable
mem_dout  input  DATA_W  memory read bus

Behaviour:
- Async reset (rst_n low): state = IDLE, prio = A, wait counter = 0, all outputs 0 including rdata, mem_adr, mem_din. Reset takes effect immediately, mid-transaction included, so mem_we/mem_oe drop without waiting for a clock edge. No ack is issued for an aborted transaction.
- All outputs come straight from flops, with no combinational path from inputs. This keeps mem_we glitch-free.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - No request: remain in IDLE.
  - Only one request high: grant it.
  - Both high: grant the side named by prio.
  - On grant: latch the granted side's we/adr/wdata into mem_adr/mem_din/op register, then go to SETUP.
- SETUP (1 cycle):
  - mem_adr and mem_din are stable.
  - mem_we = 0; mem_oe = 1 if read, else 0.
  - Load counter with ACCESS_CYCLES-1, then go to ACCESS.
- ACCESS (ACCESS_CYCLES cycles):
  - Write: mem_we = 1. Read: mem_oe = 1.
  - Counter decrements each cycle; go to DONE when it reads 0.
  - Read: on the last ACCESS edge, rdata captures mem_dout.
- DONE (1 cycle):
  - mem_we = 0; mem_oe = 0; mem_adr/mem_din held.
  - ack of the granted side = 1.
  - prio flips to the side not served, then go to IDLE.
- Latency: the req sampled on IDLE edge k gives ack high in cycle k+2+ACCESS_CYCLES. Minimum transaction period is 3+ACCESS_CYCLES cycles, because there is always one IDLE cycle between transactions.
- Requester inputs are ignored outside IDLE, and changes after grant have no effect on the current transaction.
- If req drops mid-transaction, the transaction still completes and ack still pulses.
- If req is still high in the IDLE cycle after ack, it counts as a new request (requesters must drop req on ack).
- Writes never drive mem_oe, and reads never drive mem_we. mem_we and mem_oe are never high together.
- rdata is unchanged by writes.

Test Plan:
1. Reset, then A writes 0xA5 to adr 3 (ACCESS_CYCLES=1) -> mem_we high for exactly one cycle with mem_adr=3, mem_din=0xA5; ack_a high 3 cycles after the grant edge; mem_oe stays 0.
2. A reads adr 3 after test 1 (behavioural 8x8 memory model attached) -> mem_oe high for SETUP+ACCESS; rdata=0xA5 on the ack_a cycle and held afterwards; mem_we stays 0.
3. req_a and req_b asserted together and held, each dropping req only on its ack, then re-raising -> grant order A, B, A, B; no ack_a and ack_b in the same cycle; busy low for exactly one cycle between transactions.
4. ACCESS_CYCLES=3, B writes 0x3C to adr 7 -> mem_we high for 3 consecutive cycles; ack_b 5 cycles after the grant edge.
5. rst_n pulsed low during ACCESS of a write -> mem_we and busy fall without waiting for a clock edge; no ack; prio returns to A; the next simultaneous request is granted to A.
6. Inputs adr_a/wdata_a changed to 0/0xFF during SETUP, and req_a dropped during ACCESS -> memory is written with the originally latched values; ack_a still pulses.
